// File: rtl/sha256_round_sched.sv
// SHA-256 block sequencer: eight passes through an 8-round compressor, then the
// Davies-Meyer add into the chaining state H, with multi-block chaining.

module compressor (
    input  logic [255:0]  i_state,
    input  logic [3:0]    i_r,
    input  logic [2047:0] i_w,
    output logic [255:0]  o_state
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    logic [31:0]  w_words [64];
    logic [255:0] w_stage [9];
    // Pass index only spans 0..7; the top bit of i_r is always zero.
    logic         w_unused_r;

    assign w_unused_r = i_r[3];

    for (genvar t = 0; t < 64; t++) begin : g_words
        assign w_words[t] = i_w[2047 - 32*t -: 32];
    end

    assign w_stage[0] = i_state;
    for (genvar j = 0; j < 8; j++) begin : g_round
        assign w_stage[j+1] = sha_round(w_stage[j], K[{i_r[2:0], 3'(j)}], w_words[{i_r[2:0], 3'(j)}]);
    end

    assign o_state = w_stage[8];
endmodule

module sha256_round_sched (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          blk_valid,
    output logic          blk_ready,
    input  logic          blk_first,
    input  logic          blk_last,
    input  logic [2047:0] blk_w,
    output logic          busy,
    output logic          digest_valid,
    input  logic          digest_ready,
    output logic [255:0]  digest
);
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_ADD, ST_DONE} state_t;

    state_t        r_state;
    logic [2047:0] r_w;
    logic          r_last;
    logic [2:0]    r_rcnt;
    logic [255:0]  r_h;
    logic [255:0]  r_v;
    logic [255:0]  w_comp;
    logic [255:0]  w_h_sum;

    compressor u_comp (
        .i_state (r_v),
        .i_r     ({1'b0, r_rcnt}),
        .i_w     (r_w),
        .o_state (w_comp)
    );

    always_comb begin
        w_h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_h_sum[i*32 +: 32] = r_h[i*32 +: 32] + r_v[i*32 +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
            r_h     <= IV;
            r_v     <= '0;
            // NOTE: the schedule register is cleared too, so an aborted block leaves nothing behind.
            r_w     <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        r_w     <= blk_w;
                        r_last  <= blk_last;
                        r_v     <= blk_first ? IV : r_h;
                        if (blk_first) begin
                            r_h <= IV;
                        end
                        r_rcnt  <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_v    <= w_comp;
                    r_rcnt <= r_rcnt + 3'd1;
                    if (r_rcnt == 3'd7) begin
                        r_state <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_h     <= w_h_sum;
                    r_state <= r_last ? ST_DONE : ST_IDLE;
                end
                ST_DONE: begin
                    if (digest_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign blk_ready    = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign digest_valid = (r_state == ST_DONE);
    assign digest       = r_h;
endmodule
